// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the command-sequencer state encoding.
package ps2_pkg;

   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;
   localparam logic [7:0] PS2_RESP_RESEND  = 8'hFE;

   typedef enum logic [1:0] {
      StIdle,
      StTxWait,
      StAckWait
   } ps2_cmd_state_e;

endpackage

// File: rtl/ps2_ack_timer.sv
// Saturating response timer; o_expired is high once the count reaches ACK_TIMEOUT-1.
module ps2_ack_timer #(
   parameter int unsigned ACK_TIMEOUT = 500000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_en,
   output logic o_expired
);

   localparam int unsigned W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [W-1:0] LAST = W'(ACK_TIMEOUT - 1);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en && (r_count != LAST)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_expired = (r_count == LAST);

endmodule

// File: rtl/ps2_led_cmd_ctrl.sv
// Sends the PS/2 "Set LEDs" command plus argument with ack/resend/timeout handling,
// and forwards all non-response receive bytes to the keyboard decoder.
module ps2_led_cmd_ctrl
   import ps2_pkg::*;
#(
   parameter int unsigned ACK_TIMEOUT = 500000,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic       CMD_REQ,
   input  logic [2:0] LED_STATE,
   output logic [7:0] TX_DATA,
   output logic       TX_START,
   input  logic       TX_DONE,
   input  logic       TX_ERR,
   input  logic [7:0] RX_DATA,
   input  logic       RX_VALID,
   output logic [7:0] KEY_DATA,
   output logic       KEY_VALID,
   output logic       BUSY,
   output logic       ERROR
);

   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

   ps2_cmd_state_e r_state, w_state_d;
   logic           r_pending, w_pending_d;
   logic           r_phase, w_phase_d;
   logic [RW-1:0]  r_retry, w_retry_d;
   logic [7:0]     r_arg, w_arg_d;
   logic [7:0]     r_tx_data, w_tx_data_d;
   logic           r_tx_start, w_tx_start_d;
   logic [7:0]     r_key_data, w_key_data_d;
   logic           r_key_valid, w_key_valid_d;
   logic           r_busy, w_busy_d;
   logic           r_error, w_error_d;

   logic w_expired;
   logic w_rx_ack;
   logic w_rx_resend;

   ps2_ack_timer #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_ack_timer (
      .i_clk     (CLK),
      .i_rst_n   (RESET_N),
      .i_clear   (r_state != StAckWait),
      .i_en      (r_state == StAckWait),
      .o_expired (w_expired)
   );

   assign w_rx_ack    = RX_VALID && (RX_DATA == PS2_RESP_ACK);
   assign w_rx_resend = RX_VALID && (RX_DATA == PS2_RESP_RESEND);

   always_comb begin
      w_state_d     = r_state;
      w_pending_d   = r_pending | CMD_REQ;
      w_phase_d     = r_phase;
      w_retry_d     = r_retry;
      w_arg_d       = r_arg;
      w_tx_data_d   = r_tx_data;
      w_tx_start_d  = 1'b0;
      w_key_data_d  = r_key_data;
      w_key_valid_d = 1'b0;
      w_busy_d      = r_busy;
      w_error_d     = r_error;

      // Responses are only meaningful while waiting for one; elsewhere they are scan data.
      if (RX_VALID && !((r_state == StAckWait) && (w_rx_ack || w_rx_resend))) begin
         w_key_valid_d = 1'b1;
         w_key_data_d  = RX_DATA;
      end

      unique case (r_state)
         StIdle: begin
            if (r_pending || CMD_REQ) begin
               w_arg_d      = {5'b0, LED_STATE};
               w_tx_data_d  = PS2_CMD_SET_LEDS;
               w_tx_start_d = 1'b1;
               w_phase_d    = 1'b0;
               w_retry_d    = '0;
               w_pending_d  = 1'b0;
               w_error_d    = 1'b0;
               w_busy_d     = 1'b1;
               w_state_d    = StTxWait;
            end
         end
         StTxWait, StAckWait: begin
            logic w_retry_evt;
            w_retry_evt = 1'b0;
            if (r_state == StTxWait) begin
               if (TX_ERR) begin
                  w_retry_evt = 1'b1;
               end else if (TX_DONE) begin
                  w_state_d = StAckWait;
               end
            end else if (w_rx_ack) begin
               if (!r_phase) begin
                  w_tx_data_d  = r_arg;
                  w_tx_start_d = 1'b1;
                  w_phase_d    = 1'b1;
                  w_retry_d    = '0;
                  w_state_d    = StTxWait;
               end else begin
                  w_busy_d  = 1'b0;
                  w_state_d = StIdle;
               end
            end else if (w_rx_resend || (!RX_VALID && w_expired)) begin
               w_retry_evt = 1'b1;
            end

            if (w_retry_evt) begin
               if (r_retry < RETRY_LIMIT) begin
                  w_retry_d    = r_retry + RW'(1);
                  w_tx_start_d = 1'b1;
                  w_state_d    = StTxWait;
               end else begin
                  w_error_d = 1'b1;
                  w_busy_d  = 1'b0;
                  w_state_d = StIdle;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state     <= StIdle;
         r_pending   <= 1'b0;
         r_phase     <= 1'b0;
         r_retry     <= '0;
         r_arg       <= 8'h00;
         r_tx_data   <= 8'h00;
         r_tx_start  <= 1'b0;
         r_key_data  <= 8'h00;
         r_key_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_d;
         r_pending   <= w_pending_d;
         r_phase     <= w_phase_d;
         r_retry     <= w_retry_d;
         r_arg       <= w_arg_d;
         r_tx_data   <= w_tx_data_d;
         r_tx_start  <= w_tx_start_d;
         r_key_data  <= w_key_data_d;
         r_key_valid <= w_key_valid_d;
         r_busy      <= w_busy_d;
         r_error     <= w_error_d;
      end
   end

   assign TX_DATA   = r_tx_data;
   assign TX_START  = r_tx_start;
   assign KEY_DATA  = r_key_data;
   assign KEY_VALID = r_key_valid;
   assign BUSY      = r_busy;
   assign ERROR     = r_error;

endmodule

// File: tb/tb_ps2_led_cmd_ctrl.sv
// Directed bench for ps2_led_cmd_ctrl with a short ACK timeout.
module tb_ps2_led_cmd_ctrl;

   logic       CLK;
   logic       RESET_N;
   logic       CMD_REQ;
   logic [2:0] LED_STATE;
   logic [7:0] TX_DATA;
   logic       TX_START;
   logic       TX_DONE;
   logic       TX_ERR;
   logic [7:0] RX_DATA;
   logic       RX_VALID;
   logic [7:0] KEY_DATA;
   logic       KEY_VALID;
   logic       BUSY;
   logic       ERROR;

   int checks   = 0;
   int failures = 0;
   int n_starts = 0;
   int n_keys   = 0;

   ps2_led_cmd_ctrl #(
      .ACK_TIMEOUT (16),
      .MAX_RETRY   (3)
   ) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .CMD_REQ   (CMD_REQ),
      .LED_STATE (LED_STATE),
      .TX_DATA   (TX_DATA),
      .TX_START  (TX_START),
      .TX_DONE   (TX_DONE),
      .TX_ERR    (TX_ERR),
      .RX_DATA   (RX_DATA),
      .RX_VALID  (RX_VALID),
      .KEY_DATA  (KEY_DATA),
      .KEY_VALID (KEY_VALID),
      .BUSY      (BUSY),
      .ERROR     (ERROR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (TX_START) n_starts <= n_starts + 1;
      if (KEY_VALID) n_keys <= n_keys + 1;
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic req(input logic [2:0] led);
      LED_STATE = led;
      CMD_REQ = 1'b1;
      cyc();
      CMD_REQ = 1'b0;
   endtask

   task automatic tx_done();
      TX_DONE = 1'b1;
      cyc();
      TX_DONE = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b);
      RX_DATA = b;
      RX_VALID = 1'b1;
      cyc();
      RX_VALID = 1'b0;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      CMD_REQ = 1'b0;
      LED_STATE = 3'b000;
      TX_DONE = 1'b0;
      TX_ERR = 1'b0;
      RX_DATA = 8'h00;
      RX_VALID = 1'b0;
      #3;
      checks++; if (TX_DATA !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", TX_DATA); end
      checks++; if (TX_START !== 1'b0) begin failures++; $display("FAIL reset_tx_start got=%b exp=0", TX_START); end
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
      checks++; if (ERROR !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", ERROR); end
      checks++; if (KEY_VALID !== 1'b0 || KEY_DATA !== 8'h00) begin failures++; $display("FAIL reset_key got=%b/%h exp=0/00", KEY_VALID, KEY_DATA); end
      cyc(2);
      RESET_N = 1'b1;
      cyc(2);
   endtask

   task automatic test_normal();
      int s0, k0;
      s0 = n_starts;
      req(3'b101);
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'hED) begin failures++; $display("FAIL normal_cmd got=%b/%h exp=1/ed", TX_START, TX_DATA); end
      checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL normal_busy got=%b exp=1", BUSY); end
      cyc();
      checks++; if (TX_START !== 1'b0) begin failures++; $display("FAIL normal_start_width got=%b exp=0", TX_START); end
      tx_done();
      rx(8'hFA);
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'h05) begin failures++; $display("FAIL normal_arg got=%b/%h exp=1/05", TX_START, TX_DATA); end
      k0 = n_keys;
      tx_done();
      rx(8'hFA);
      checks++; if (BUSY !== 1'b0 || ERROR !== 1'b0) begin failures++; $display("FAIL normal_done got=busy%b err%b exp=0/0", BUSY, ERROR); end
      cyc(3);
      checks++; if (n_keys - k0 !== 0) begin failures++; $display("FAIL normal_no_key got=%0d exp=0", n_keys - k0); end
      checks++; if (n_starts - s0 !== 2) begin failures++; $display("FAIL normal_starts got=%0d exp=2", n_starts - s0); end
   endtask

   task automatic test_resend_abort();
      int s0;
      s0 = n_starts;
      req(3'b010);
      tx_done();
      rx(8'hFE);
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'hED) begin failures++; $display("FAIL resend_retx got=%b/%h exp=1/ed", TX_START, TX_DATA); end
      for (int i = 0; i < 3; i++) begin
         tx_done();
         rx(8'hFE);
      end
      checks++; if (ERROR !== 1'b1 || BUSY !== 1'b0) begin failures++; $display("FAIL resend_abort got=err%b busy%b exp=1/0", ERROR, BUSY); end
      cyc(3);
      checks++; if (n_starts - s0 !== 4) begin failures++; $display("FAIL resend_starts got=%0d exp=4", n_starts - s0); end
   endtask

   task automatic test_tx_err();
      int s0;
      s0 = n_starts;
      req(3'b011);
      checks++; if (ERROR !== 1'b0) begin failures++; $display("FAIL txerr_error_cleared got=%b exp=0", ERROR); end
      TX_DONE = 1'b1;
      TX_ERR = 1'b1;
      cyc();
      TX_DONE = 1'b0;
      TX_ERR = 1'b0;
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'hED) begin failures++; $display("FAIL txerr_wins got=%b/%h exp=1/ed", TX_START, TX_DATA); end
      tx_done();
      rx(8'hFA);
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'h03) begin failures++; $display("FAIL txerr_arg got=%b/%h exp=1/03", TX_START, TX_DATA); end
      tx_done();
      rx(8'hFA);
      cyc();
      checks++; if (BUSY !== 1'b0 || n_starts - s0 !== 3) begin failures++; $display("FAIL txerr_done got=busy%b starts%0d exp=0/3", BUSY, n_starts - s0); end
   endtask

   task automatic test_timeout();
      int early;
      req(3'b001);
      for (int k = 0; k < 3; k++) begin
         tx_done();
         early = 0;
         for (int i = 0; i < 15; i++) begin
            cyc();
            if (TX_START) early++;
         end
         checks++; if (early !== 0) begin failures++; $display("FAIL timeout_early%0d got=%0d exp=0", k, early); end
         cyc();
         checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'hED) begin failures++; $display("FAIL timeout_retx%0d got=%b/%h exp=1/ed", k, TX_START, TX_DATA); end
      end
      tx_done();
      cyc(16);
      checks++; if (ERROR !== 1'b1 || BUSY !== 1'b0 || TX_START !== 1'b0) begin failures++; $display("FAIL timeout_abort got=err%b busy%b st%b exp=1/0/0", ERROR, BUSY, TX_START); end
      // Response on the very cycle the timer expires must be taken as the ACK.
      req(3'b110);
      tx_done();
      cyc(15);
      rx(8'hFA);
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'h06) begin failures++; $display("FAIL timeout_rx_wins got=%b/%h exp=1/06", TX_START, TX_DATA); end
      tx_done();
      rx(8'hFA);
      checks++; if (BUSY !== 1'b0 || ERROR !== 1'b0) begin failures++; $display("FAIL timeout_rx_done got=busy%b err%b exp=0/0", BUSY, ERROR); end
   endtask

   task automatic test_forwarding();
      logic [7:0] seq [4];
      seq[0] = 8'h1C;
      seq[1] = 8'hF0;
      seq[2] = 8'h1C;
      seq[3] = 8'hFA;
      for (int i = 0; i < 4; i++) begin
         rx(seq[i]);
         checks++; if (KEY_VALID !== 1'b1 || KEY_DATA !== seq[i]) begin failures++; $display("FAIL fwd_idle%0d got=%b/%h exp=1/%h", i, KEY_VALID, KEY_DATA, seq[i]); end
      end
      cyc();
      checks++; if (KEY_VALID !== 1'b0) begin failures++; $display("FAIL fwd_strobe_width got=%b exp=0", KEY_VALID); end
      req(3'b100);
      tx_done();
      rx(8'h1C);
      checks++; if (KEY_VALID !== 1'b1 || KEY_DATA !== 8'h1C || TX_START !== 1'b0) begin failures++; $display("FAIL fwd_ackwait got=%b/%h st%b exp=1/1c/0", KEY_VALID, KEY_DATA, TX_START); end
      rx(8'hFA);
      checks++; if (KEY_VALID !== 1'b0 || TX_START !== 1'b1 || TX_DATA !== 8'h04) begin failures++; $display("FAIL fwd_ack_swallow got=%b st%b %h exp=0/1/04", KEY_VALID, TX_START, TX_DATA); end
      tx_done();
      rx(8'hFE);
      checks++; if (KEY_VALID !== 1'b0 || TX_START !== 1'b1 || TX_DATA !== 8'h04) begin failures++; $display("FAIL fwd_resend_swallow got=%b st%b %h exp=0/1/04", KEY_VALID, TX_START, TX_DATA); end
      tx_done();
      rx(8'hFA);
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL fwd_done got=%b exp=0", BUSY); end
   endtask

   task automatic test_back_to_back();
      int s0;
      s0 = n_starts;
      req(3'b001);
      req(3'b010);
      tx_done();
      req(3'b100);
      rx(8'hFA);
      checks++; if (TX_DATA !== 8'h01) begin failures++; $display("FAIL b2b_first_arg got=%h exp=01", TX_DATA); end
      tx_done();
      rx(8'hFA);
      checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL b2b_first_done got=%b exp=0", BUSY); end
      cyc();
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'hED || BUSY !== 1'b1) begin failures++; $display("FAIL b2b_follow got=%b/%h busy%b exp=1/ed/1", TX_START, TX_DATA, BUSY); end
      tx_done();
      rx(8'hFA);
      checks++; if (TX_DATA !== 8'h04) begin failures++; $display("FAIL b2b_latest_led got=%h exp=04", TX_DATA); end
      tx_done();
      // Request coinciding with completion starts one cycle after BUSY drops.
      LED_STATE = 3'b111;
      CMD_REQ = 1'b1;
      rx(8'hFA);
      CMD_REQ = 1'b0;
      checks++; if (BUSY !== 1'b0 || TX_START !== 1'b0) begin failures++; $display("FAIL b2b_complete got=busy%b st%b exp=0/0", BUSY, TX_START); end
      cyc();
      checks++; if (TX_START !== 1'b1 || TX_DATA !== 8'hED) begin failures++; $display("FAIL b2b_req_at_done got=%b/%h exp=1/ed", TX_START, TX_DATA); end
      tx_done();
      rx(8'hFA);
      tx_done();
      rx(8'hFA);
      cyc(5);
      checks++; if (n_starts - s0 !== 6 || BUSY !== 1'b0) begin failures++; $display("FAIL b2b_starts got=%0d busy%b exp=6/0", n_starts - s0, BUSY); end
   endtask

   task automatic test_reset_mid();
      int s0;
      req(3'b111);
      #2;
      RESET_N = 1'b0;
      #1;
      checks++; if (TX_START !== 1'b0 || BUSY !== 1'b0 || TX_DATA !== 8'h00 || ERROR !== 1'b0) begin failures++; $display("FAIL rst_mid_async got=st%b busy%b %h err%b exp=0/0/00/0", TX_START, BUSY, TX_DATA, ERROR); end
      s0 = n_starts;
      cyc(2);
      RESET_N = 1'b1;
      tx_done();
      rx(8'hFA);
      cyc(5);
      checks++; if (n_starts - s0 !== 0 || BUSY !== 1'b0) begin failures++; $display("FAIL rst_mid_no_start got=%0d busy%b exp=0/0", n_starts - s0, BUSY); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_resend_abort();
      test_tx_err();
      test_timeout();
      test_forwarding();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
